// File: rtl/phase_timer_pkg.sv
// Shared constants and FSM encoding for the phase countdown timer.
package phase_timer_pkg;

  localparam int DEF_TICKS_PER_SEC = 10000;
  localparam int DEF_SEC_W         = 16;
  localparam int DEF_TICK_W        = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

endpackage

// File: rtl/phase_countdown_timer_if.sv
// Timer bus between the light-sequencing FSM (master) and the countdown timer (slave).
// The pause wire exists only when PHASE_TIMER_PAUSE_EN is defined.
interface phase_countdown_timer_if
  import phase_timer_pkg::*;
#(
  parameter int SEC_W = DEF_SEC_W
) ();

  logic             start;
  logic [SEC_W-1:0] secs_in;
`ifdef PHASE_TIMER_PAUSE_EN
  logic             pause;
`endif
  logic             finished;
  logic             expired;
  logic [SEC_W-1:0] secs_left;

  modport master (
`ifdef PHASE_TIMER_PAUSE_EN
    output pause,
`endif
    output start, secs_in,
    input  finished, expired, secs_left
  );

  modport slave (
`ifdef PHASE_TIMER_PAUSE_EN
    input  pause,
`endif
    input  start, secs_in,
    output finished, expired, secs_left
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle sec_tick every TICKS_PER_SEC enabled cycles.
// Clear has priority over enable and returns the count to zero.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 10000,
  parameter int TICK_W        = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_sec_tick
);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_at_wrap;

  assign w_at_wrap  = (r_tick_cnt == TICK_W'(TICKS_PER_SEC - 1));
  assign o_sec_tick = i_en && w_at_wrap;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_tick_cnt <= '0;
    end else if (i_en) begin
      r_tick_cnt <= w_at_wrap ? '0 : r_tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/phase_countdown_timer.sv
// Seconds countdown for each light phase; finished is low for exactly N*TICKS_PER_SEC cycles.
// Optional freeze input is enabled by defining PHASE_TIMER_PAUSE_EN.
module phase_countdown_timer
  import phase_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int SEC_W         = DEF_SEC_W,
  parameter int TICK_W        = DEF_TICK_W
) (
  input  logic                   clk,
  input  logic                   reset,
  phase_countdown_timer_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEC_W-1:0] r_sec_cnt;
  logic [SEC_W-1:0] w_sec_cnt_nxt;
  logic [SEC_W-1:0] r_secs_left;
  logic             w_pause;
  logic             w_load;
  logic             w_run_en;
  logic             w_clear;
  logic             w_sec_tick;

`ifdef PHASE_TIMER_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_load   = bus.start && (bus.secs_in != '0);
  // Any start (load or abort) restarts the second boundary from zero.
  assign w_clear  = (r_state != ST_RUN) || bus.start;
  assign w_run_en = (r_state == ST_RUN) && !bus.start && !w_pause;

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .TICK_W        (TICK_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_en       (w_run_en),
    .o_sec_tick (w_sec_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_sec_cnt_nxt = r_sec_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt   = ST_RUN;
          w_sec_cnt_nxt = bus.secs_in;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          if (w_load) begin
            w_sec_cnt_nxt = bus.secs_in;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_sec_cnt_nxt = '0;
          end
        end else if (w_sec_tick) begin
          // Last second completes straight into EXPIRE, so sec_cnt never wraps.
          if (r_sec_cnt == SEC_W'(1)) begin
            w_state_nxt   = ST_EXPIRE;
            w_sec_cnt_nxt = '0;
          end else begin
            w_sec_cnt_nxt = r_sec_cnt - SEC_W'(1);
          end
        end
      end
      ST_EXPIRE: begin
        if (w_load) begin
          w_state_nxt   = ST_RUN;
          w_sec_cnt_nxt = bus.secs_in;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_sec_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sec_cnt   <= '0;
      r_secs_left <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sec_cnt   <= w_sec_cnt_nxt;
      r_secs_left <= (w_state_nxt == ST_RUN) ? w_sec_cnt_nxt : '0;
    end
  end

  assign bus.finished  = (r_state != ST_RUN);
  assign bus.expired   = (r_state == ST_EXPIRE);
  assign bus.secs_left = r_secs_left;

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Randomized and directed bench for phase_countdown_timer against a remaining-cycles model.
// Pause scenario is compiled in only with PHASE_TIMER_PAUSE_EN.
module tb_phase_countdown_timer;

  localparam int T  = 4;
  localparam int SW = 16;
  localparam logic [SW+1:0] IDLE_VEC = {1'b1, 1'b0, {SW{1'b0}}};

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // Model: cycles of countdown still owed; expired marks the cycle after it hits zero.
  int   m_rem = 0;
  bit   m_exp = 1'b0;

  phase_countdown_timer_if #(.SEC_W(SW)) bus ();

  phase_countdown_timer #(
    .TICKS_PER_SEC (T),
    .SEC_W         (SW),
    .TICK_W        (14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [SW+1:0] model_vec();
    int s;
    s = (m_rem > 0) ? (m_rem + T - 1) / T : 0;
    return {m_rem == 0, m_exp, SW'(s)};
  endfunction

  function automatic logic [SW+1:0] obs_vec();
    return {bus.finished, bus.expired, bus.secs_left};
  endfunction

  task automatic drive(input bit st, input int n);
    bus.start   = st;
    bus.secs_in = SW'(n);
  endtask

  task automatic set_pause(input bit p);
`ifdef PHASE_TIMER_PAUSE_EN
    bus.pause = p;
`else
    if (p) begin end
`endif
  endtask

  task automatic tick();
    bit p;
    @(posedge clk);
`ifdef PHASE_TIMER_PAUSE_EN
    p = bus.pause;
`else
    p = 1'b0;
`endif
    if (reset) begin
      m_rem = 0; m_exp = 1'b0;
    end else if (bus.start && bus.secs_in != '0) begin
      m_rem = int'(bus.secs_in) * T; m_exp = 1'b0;
    end else if (bus.start) begin
      m_rem = 0; m_exp = 1'b0;
    end else if (m_rem > 0 && !p) begin
      m_rem = m_rem - 1; m_exp = (m_rem == 0);
    end else begin
      m_exp = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5);
    repeat (3) begin
      tick();
      checks++;
      if (obs_vec() !== IDLE_VEC) begin
        errors++;
        $display("FAIL reset_hold got=%h want=%h", obs_vec(), IDLE_VEC);
      end
    end
    reset = 1'b0;
    drive(1'b0, 0);
    tick();
    checks++;
    if (obs_vec() !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_basic();
    int low = 0, pulses = 0;
    drive(1'b1, 3);
    tick();
    drive(1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL basic_cycle%0d got=%h want=%h", i, obs_vec(), model_vec());
      end
      if (i % 4 == 0 && i < 12) begin
        checks++;
        if (bus.secs_left !== SW'(3 - i / 4)) begin
          errors++;
          $display("FAIL basic_secs_left cycle%0d got=%0d want=%0d", i, bus.secs_left, 3 - i / 4);
        end
      end
      if (!bus.finished) low++;
      if (bus.expired) pulses++;
      tick();
    end
    checks++;
    if (low != 12) begin
      errors++;
      $display("FAIL basic_low_cycles got=%0d want=12", low);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL basic_expired_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    drive(1'b1, 1);
    tick();
    drive(1'b0, 0);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.expired) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_expire_timeout got=0 want=1");
    end
    drive(1'b1, 2);
    tick();
    drive(1'b0, 0);
    checks++;
    if (obs_vec() !== {1'b0, 1'b0, SW'(2)}) begin
      errors++;
      $display("FAIL b2b_reload got=%h want=%h", obs_vec(), {1'b0, 1'b0, SW'(2)});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", i, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_restart();
    int low = 0, pulses = 0;
    drive(1'b1, 5);
    tick();
    drive(1'b0, 0);
    repeat (5) tick();
    drive(1'b1, 2);
    tick();
    drive(1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL restart_cycle%0d got=%h want=%h", i, obs_vec(), model_vec());
      end
      if (!bus.finished) low++;
      if (bus.expired) pulses++;
      tick();
    end
    checks++;
    if (low != 8) begin
      errors++;
      $display("FAIL restart_low_cycles got=%0d want=8", low);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL restart_expired_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_zero_start();
    int pulses = 0;
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    checks++;
    if (obs_vec() !== IDLE_VEC) begin
      errors++;
      $display("FAIL zero_idle got=%h want=%h", obs_vec(), IDLE_VEC);
    end
    drive(1'b1, 3);
    tick();
    drive(1'b0, 0);
    repeat (4) tick();
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    checks++;
    if (obs_vec() !== IDLE_VEC) begin
      errors++;
      $display("FAIL zero_abort got=%h want=%h", obs_vec(), IDLE_VEC);
    end
    repeat (16) begin
      tick();
      if (bus.expired) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL zero_abort_expired got=%0d want=0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    drive(1'b1, 3);
    tick();
    drive(1'b0, 0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_vec() !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", obs_vec(), IDLE_VEC);
    end
    repeat (16) begin
      tick();
      if (bus.expired) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_expired got=%0d want=0", pulses);
    end
  endtask

`ifdef PHASE_TIMER_PAUSE_EN
  task automatic test_pause();
    int low = 0, pulses = 0;
    drive(1'b1, 2);
    tick();
    drive(1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL pause_cycle%0d got=%h want=%h", i, obs_vec(), model_vec());
      end
      if (!bus.finished) low++;
      if (bus.expired) pulses++;
      set_pause(i >= 3 && i < 13);
      tick();
    end
    set_pause(1'b0);
    checks++;
    if (low != 18) begin
      errors++;
      $display("FAIL pause_low_cycles got=%0d want=18", low);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL pause_expired_pulses got=%0d want=1", pulses);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 4)));
      set_pause($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, obs_vec(), model_vec());
      end
    end
    reset = 1'b0;
    drive(1'b0, 0);
    set_pause(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 0);
    set_pause(1'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_restart();
    test_zero_start();
    test_reset_mid();
`ifdef PHASE_TIMER_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
